// File: rtl/channel_scale_unit_pkg.sv
// Shared types and width helpers for the channel scaling stage.
package channel_scale_unit_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GATE_REQ,
    S_GATE_LATCH,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  function automatic int unsigned pixel_count(input int unsigned img_w, input int unsigned img_h);
    return img_w * img_h;
  endfunction

  // Product width, plus one guard bit so the rounding bias cannot overflow.
  function automatic int unsigned prod_w(input int unsigned data_w);
    return 2 * data_w;
  endfunction

  function automatic int unsigned round_w(input int unsigned data_w);
    return 2 * data_w + 1;
  endfunction

endpackage

// File: rtl/channel_scale_unit_gate_mul_sat.sv
// Single-channel signed multiply by a fixed-point gate, round half up, saturate.
module gate_mul_sat
  import channel_scale_unit_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned GATE_FRAC = 7
) (
  input  logic signed [DATA_W-1:0] fm,
  input  logic signed [DATA_W-1:0] gate_val,
  output logic signed [DATA_W-1:0] scaled
);

  localparam int unsigned PW = prod_w(DATA_W);
  localparam int unsigned RW = round_w(DATA_W);
  localparam logic signed [RW-1:0] BIAS    = RW'(2 ** (GATE_FRAC - 1));
  localparam logic signed [RW-1:0] SAT_MAX = RW'(2 ** (DATA_W - 1) - 1);
  localparam logic signed [RW-1:0] SAT_MIN = RW'(-(2 ** (DATA_W - 1)));

  logic signed [PW-1:0] prod;
  logic signed [RW-1:0] biased;
  logic signed [RW-1:0] rounded;

  always_comb begin
    prod    = fm * gate_val;
    biased  = {prod[PW-1], prod} + BIAS;
    rounded = biased >>> GATE_FRAC;
    if (rounded > SAT_MAX) begin
      scaled = SAT_MAX[DATA_W-1:0];
    end else if (rounded < SAT_MIN) begin
      scaled = SAT_MIN[DATA_W-1:0];
    end else begin
      scaled = rounded[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/channel_scale_unit.sv
// Scales every pixel of the feature map by a per-channel gate latched once per frame.
module channel_scale_unit
  import channel_scale_unit_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned IN_CH     = 8,
  parameter int unsigned IMG_W     = 5,
  parameter int unsigned IMG_H     = 4,
  parameter int unsigned FM_ADDR_W = 10,
  parameter int unsigned GATE_FRAC = 7
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_clk_en,
  input  logic                      i_start,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_gate_rd_addr,
  input  logic [IN_CH*DATA_W-1:0]   i_gate_rd_data_flat,
  output logic                      o_fm_rd_en,
  output logic [FM_ADDR_W-1:0]      o_fm_rd_addr,
  input  logic [IN_CH*DATA_W-1:0]   i_fm_rd_data_flat,
  output logic                      o_out_wr_en,
  output logic [FM_ADDR_W-1:0]      o_out_wr_addr,
  output logic [IN_CH*DATA_W-1:0]   o_out_wr_data_flat
);

  localparam int unsigned          PIXEL_COUNT = pixel_count(IMG_W, IMG_H);
  localparam logic [FM_ADDR_W-1:0] LAST_PIX    = FM_ADDR_W'(PIXEL_COUNT - 1);

  state_t                    state, state_nxt;
  logic [FM_ADDR_W-1:0]      rd_cnt, rd_addr_d1, wr_addr_q;
  logic                      rd_vld_d1, wr_vld_q;
  logic [IN_CH*DATA_W-1:0]   gate_q, scaled_flat, wr_data_q;
  logic                      stream_rd;

  assign stream_rd = (state == S_STREAM);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:       if (i_start) state_nxt = S_GATE_REQ;
      S_GATE_REQ:   state_nxt = S_GATE_LATCH;
      S_GATE_LATCH: state_nxt = S_STREAM;
      S_STREAM:     if (rd_cnt == LAST_PIX) state_nxt = S_DRAIN;
      S_DRAIN:      if (wr_vld_q && (wr_addr_q == LAST_PIX)) state_nxt = S_DONE;
      S_DONE:       state_nxt = S_IDLE;
      default:      state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else if (i_clk_en) begin
      state <= state_nxt;
    end
  end

  // Read strobe and address travel two stages so the write lines up with the registered product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt     <= '0;
      rd_addr_d1 <= '0;
      wr_addr_q  <= '0;
      rd_vld_d1  <= 1'b0;
      wr_vld_q   <= 1'b0;
      gate_q     <= '0;
      wr_data_q  <= '0;
    end else if (i_clk_en) begin
      rd_cnt     <= stream_rd ? rd_cnt + FM_ADDR_W'(1) : '0;
      rd_addr_d1 <= rd_cnt;
      wr_addr_q  <= rd_addr_d1;
      rd_vld_d1  <= stream_rd;
      wr_vld_q   <= rd_vld_d1;
      if (rd_vld_d1) wr_data_q <= scaled_flat;
      if (state == S_GATE_LATCH) begin
        for (int unsigned c = 0; c < IN_CH; c++) begin
          gate_q[c*DATA_W +: DATA_W] <= i_gate_rd_data_flat[c*DATA_W + DATA_W - 1]
                                        ? '0 : i_gate_rd_data_flat[c*DATA_W +: DATA_W];
        end
      end
    end
  end

  for (genvar c = 0; c < IN_CH; c++) begin : g_ch
    gate_mul_sat #(
      .DATA_W   (DATA_W),
      .GATE_FRAC(GATE_FRAC)
    ) u_mul (
      .fm      (i_fm_rd_data_flat[c*DATA_W +: DATA_W]),
      .gate_val(gate_q[c*DATA_W +: DATA_W]),
      .scaled  (scaled_flat[c*DATA_W +: DATA_W])
    );
  end

  assign o_busy             = (state != S_IDLE);
  assign o_done             = (state == S_DONE) && i_clk_en;
  assign o_gate_rd_addr     = 1'b0;
  assign o_fm_rd_en         = stream_rd && i_clk_en;
  assign o_fm_rd_addr       = rd_cnt;
  assign o_out_wr_en        = wr_vld_q && i_clk_en;
  assign o_out_wr_addr      = wr_addr_q;
  assign o_out_wr_data_flat = wr_data_q;

endmodule

// File: tb/tb_channel_scale_unit.sv
// Directed scoreboard bench for channel_scale_unit.
module tb_channel_scale_unit;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned IN_CH  = 8;
  localparam int unsigned NPIX   = 20;
  localparam int unsigned AW     = 10;
  localparam int unsigned FW     = IN_CH * DATA_W;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_clk_en;
  logic          i_start;
  logic          o_busy, o_done, o_gate_rd_addr;
  logic [FW-1:0] i_gate_rd_data_flat;
  logic          o_fm_rd_en;
  logic [AW-1:0] o_fm_rd_addr;
  logic [FW-1:0] i_fm_rd_data_flat;
  logic          o_out_wr_en;
  logic [AW-1:0] o_out_wr_addr;
  logic [FW-1:0] o_out_wr_data_flat;

  channel_scale_unit #(
    .DATA_W   (8),
    .IN_CH    (8),
    .IMG_W    (5),
    .IMG_H    (4),
    .FM_ADDR_W(10),
    .GATE_FRAC(7)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .i_clk_en           (i_clk_en),
    .i_start            (i_start),
    .o_busy             (o_busy),
    .o_done             (o_done),
    .o_gate_rd_addr     (o_gate_rd_addr),
    .i_gate_rd_data_flat(i_gate_rd_data_flat),
    .o_fm_rd_en         (o_fm_rd_en),
    .o_fm_rd_addr       (o_fm_rd_addr),
    .i_fm_rd_data_flat  (i_fm_rd_data_flat),
    .o_out_wr_en        (o_out_wr_en),
    .o_out_wr_addr      (o_out_wr_addr),
    .o_out_wr_data_flat (o_out_wr_data_flat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [FW-1:0] data;
  } exp_t;

  exp_t          sbq[$];
  logic [FW-1:0] mem [NPIX];
  int            total = 0;
  int            bad = 0;
  int            wr_count = 0;
  int            done_count = 0;
  bit            prev_last = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_ch(input logic signed [7:0] fm, input logic signed [7:0] g);
    int gi, num, r;
    gi  = (g < 0) ? 0 : int'(g);
    num = int'(fm) * gi + 64;
    if (num >= 0) r = num / 128;
    else          r = -((-num + 127) / 128);
    if (r > 127)  r = 127;
    if (r < -128) r = -128;
    return r[7:0];
  endfunction

  // Feature-map BRAM: registered read, output holds when not strobed.
  always @(posedge clk) begin
    if (o_fm_rd_en) i_fm_rd_data_flat <= mem[o_fm_rd_addr];
  end

  always @(negedge clk) begin
    if (rst) begin
      prev_last = 1'b0;
    end else if (!i_clk_en) begin
      check("strobes_off", {61'd0, o_fm_rd_en, o_out_wr_en, o_done}, 64'd0);
    end else begin
      if (o_done) begin
        done_count++;
        check("done_after_last", {63'd0, prev_last}, 64'd1);
      end
      if (o_out_wr_en) begin
        exp_t e;
        wr_count++;
        check("write_expected", {63'd0, sbq.size() != 0}, 64'd1);
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          check("wr_addr", {54'd0, o_out_wr_addr}, {54'd0, e.addr});
          check("wr_data", o_out_wr_data_flat, e.data);
        end
      end
      prev_last = o_out_wr_en && (o_out_wr_addr == AW'(NPIX - 1));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame();
    exp_t e;
    logic [FW-1:0] px, g;
    g = i_gate_rd_data_flat;
    for (int p = 0; p < int'(NPIX); p++) begin
      px = mem[p];
      e.addr = AW'(p);
      for (int c = 0; c < int'(IN_CH); c++)
        e.data[c*8 +: 8] = exp_ch(px[c*8 +: 8], g[c*8 +: 8]);
      sbq.push_back(e);
    end
  endtask

  task automatic start_frame();
    push_frame();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check("busy_after_start", {63'd0, o_busy}, 64'd1);
    check("no_rd_cycle1", {63'd0, o_fm_rd_en}, 64'd0);
    tick();
    check("no_rd_cycle2", {63'd0, o_fm_rd_en}, 64'd0);
    tick();
    check("first_rd_cycle3", {53'd0, o_fm_rd_en, o_fm_rd_addr}, {53'd0, 1'b1, 10'd0});
  endtask

  task automatic wait_done(input int prev);
    for (int i = 0; i < 300 && done_count == prev; i++) tick();
    check("done_seen", {63'd0, done_count > prev}, 64'd1);
  endtask

  task automatic end_frame(input int w0);
    check("frame_writes", 64'(wr_count - w0), 64'(NPIX));
    check("sb_empty", 64'(sbq.size()), 64'd0);
  endtask

  task automatic fill_random();
    for (int p = 0; p < int'(NPIX); p++) mem[p] = {$urandom, $urandom};
  endtask

  initial begin
    int w0, d0;
    byte r0[4];
    logic [FW-1:0] tmp;
    r0 = '{-3, 3, -1, 100};
    rst = 1'b1; i_clk_en = 1'b1; i_start = 1'b0;
    i_gate_rd_data_flat = '0; i_fm_rd_data_flat = '0;
    for (int p = 0; p < int'(NPIX); p++) mem[p] = '0;
    tick(); tick();
    check("rst_ctrl", {59'd0, o_busy, o_done, o_gate_rd_addr, o_fm_rd_en, o_out_wr_en}, 64'd0);
    check("rst_addr", {44'd0, o_fm_rd_addr, o_out_wr_addr}, 64'd0);
    check("rst_data", o_out_wr_data_flat, 64'd0);
    rst = 1'b0;
    tick();

    // Uniform frame: gate 0.5, fm 100 -> 50 everywhere.
    for (int p = 0; p < int'(NPIX); p++) mem[p] = {8{8'd100}};
    i_gate_rd_data_flat = {8{8'd64}};
    w0 = wr_count; d0 = done_count;
    start_frame();
    wait_done(d0);
    end_frame(w0);

    // Rounding, saturation edges, negative gate clamp, gate port changed after latch.
    fill_random();
    for (int p = 0; p < 4; p++) begin
      tmp = mem[p]; tmp[7:0] = r0[p]; mem[p] = tmp;
    end
    tmp = mem[0]; tmp[15:8] = 8'sd127;  mem[0] = tmp;
    tmp = mem[1]; tmp[15:8] = -8'sd128; mem[1] = tmp;
    tmp = {$urandom, $urandom};
    tmp[23:0] = {8'hFB, 8'd127, 8'd64};
    i_gate_rd_data_flat = tmp;
    w0 = wr_count; d0 = done_count;
    start_frame();
    i_gate_rd_data_flat = {8{8'h11}};
    wait_done(d0);
    end_frame(w0);

    // Clock enable dropped for three cycles mid-stream.
    fill_random();
    i_gate_rd_data_flat = {$urandom, $urandom};
    w0 = wr_count; d0 = done_count;
    start_frame();
    repeat (5) tick();
    i_clk_en = 1'b0;
    repeat (3) tick();
    i_clk_en = 1'b1;
    wait_done(d0);
    end_frame(w0);

    // Start pulsed while streaming must be ignored.
    fill_random();
    i_gate_rd_data_flat = {$urandom, $urandom};
    w0 = wr_count; d0 = done_count;
    start_frame();
    repeat (4) tick();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    wait_done(d0);
    repeat (40) tick();
    check("single_done", 64'(done_count - d0), 64'd1);
    check("idle_after", {63'd0, o_busy}, 64'd0);
    end_frame(w0);

    // Reset while pixel 7 is being read.
    fill_random();
    i_gate_rd_data_flat = {$urandom, $urandom};
    start_frame();
    for (int i = 0; i < 50 && !(o_fm_rd_en && o_fm_rd_addr == 10'd7); i++) tick();
    check("reached_pix7", {53'd0, o_fm_rd_en, o_fm_rd_addr}, {53'd0, 1'b1, 10'd7});
    rst = 1'b1;
    #1;
    check("abort_ctrl", {60'd0, o_busy, o_done, o_fm_rd_en, o_out_wr_en}, 64'd0);
    check("abort_addr", {44'd0, o_fm_rd_addr, o_out_wr_addr}, 64'd0);
    check("abort_data", o_out_wr_data_flat, 64'd0);
    sbq.delete();
    w0 = wr_count;
    tick(); tick();
    rst = 1'b0;
    repeat (30) tick();
    check("no_writes_after_abort", 64'(wr_count - w0), 64'd0);
    check("idle_after_abort", {63'd0, o_busy}, 64'd0);

    fill_random();
    i_gate_rd_data_flat = {$urandom, $urandom};
    w0 = wr_count; d0 = done_count;
    start_frame();
    wait_done(d0);
    end_frame(w0);

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
